aha_ahb_sram_bridge: RTL
========================

# aha_ahb_sram_bridge

AHB-Lite slave front end that drives a single-port, byte-strobed SRAM with one-cycle registered read latency (CS/WE/ADDR/WDATA in, RDATA out, RDATA cleared on reset). Sits between the AHB interconnect and the SRAM macro or its simulation view, and sustains zero-wait-state reads and writes. A one-entry write buffer resolves the port conflict when a write data phase coincides with a read address phase. A byte-merge path returns buffered write data on read-after-write hazards.

## Interface
- ADDR_WIDTH, 14: SRAM word-address width.
- DATA_WIDTH, 32: data width; legal values are 32 and 64. NB = DATA_WIDTH/8 and OB = log2(NB).
- CLK  in  1  clock; all state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH+OB  byte address.
- HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ.
- HWRITE  in  1  1 means write.
- HSIZE  in  3  transfer size.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus ready.
- HREADYOUT  out  1  constant 1.
- HRESP  out  1  constant 0 (OKAY).
- HRDATA  out  DATA_WIDTH  read data.
- SRAM_CS  out  1  SRAM chip select.
- SRAM_WE  out  NB  SRAM byte write enables.
- SRAM_ADDR  out  ADDR_WIDTH  SRAM word address.
- SRAM_WDATA  out  DATA_WIDTH  SRAM write data.
- SRAM_RDATA  in  DATA_WIDTH  SRAM registered read data.

## Operation
- Transfer accepted when HSEL & HREADY & HTRANS[1]. Other cycles are non-transfers for this block.
- Byte mask is built from HSIZE and HADDR[OB-1:0]:
  - Aligned byte, halfword, word or doubleword lanes.
  - HSIZE at or above OB selects all lanes.
  - Misaligned low address bits are ignored within the sized lane group.
- Read address phase (RAP):
  - SRAM_CS=1, SRAM_WE=0, SRAM_ADDR=HADDR word address, all combinational.
  - Data is returned in the next cycle (the read data phase).
- Write address phase: register wr_pend=1, wr_addr and wr_mask.
- Write data phase (wr_pend=1):
  - If the same cycle is not a RAP: commit directly. SRAM_CS=1, SRAM_WE=wr_mask, SRAM_ADDR=wr_addr, SRAM_WDATA=HWDATA.
  - If the same cycle is a RAP: load the buffer instead (buf_valid=1, buf_addr, buf_mask, buf_data=HWDATA).
- Buffer commit: in any cycle with buf_valid=1 and no RAP, drive buf_addr, buf_mask and buf_data to the SRAM, and clear buf_valid at the edge.
  - Every write address phase is a non-RAP cycle, so the buffer is empty before the next write data phase.
  - One entry is therefore sufficient; a direct commit and a buffer commit never coincide.
- SRAM port priority: RAP, then buffer commit, then direct write-data-phase commit. At most one SRAM access per cycle.
- Hazard merge, evaluated at RAP:
  - merge_mask = buf_mask if buf_valid and buf_addr matches the read address.
  - OR wr_mask if wr_pend and wr_addr matches the read address.
  - merge_mask is registered into the read data phase.
- Read data phase: HRDATA byte i = buf_data byte i if merge_mask[i], else SRAM_RDATA byte i. Merge data always comes from the buffer registers, which hold the hazard data in both cases.
- Non-read cycles: merge_mask registers to 0 and HRDATA follows SRAM_RDATA.

## Timing
- Reset state (RESETn low):
  - wr_pend=0, buf_valid=0, merge_mask=0. SRAM_CS=0 and SRAM_WE=0, forced.
  - HREADYOUT=1, HRESP=0. HRDATA=SRAM_RDATA, which is 0 from the SRAM reset.
- Read latency: address phase at cycle n gives HRDATA valid in cycle n+1. Zero wait states.
- Write latency: the SRAM is updated at the end of the data phase, or at the end of the first subsequent non-RAP cycle if the write was buffered.
- Back-to-back reads: the buffer is held indefinitely and every read merges correctly.
- Reset mid-operation: pending and buffered writes are discarded. No SRAM access until the first transfer after RESETn rises.
- HREADY low with HSEL high: no new transfer is accepted. A pending write data phase still completes.

## Test plan
- Reset: assert RESETn low mid-burst, then release. Required: SRAM_CS=0 during reset, HRDATA=0, and the buffered write never reaches the SRAM.
- Word write 0xDEADBEEF to 0x10, IDLE, read 0x10. Required: SRAM_WE=0xF at the data phase, and HRDATA=0xDEADBEEF one cycle after the read address phase.
- Write byte 0xAA to 0x21, immediately followed by a read of 0x20 (hazard). Required: buf_valid=1, HRDATA[15:8]=0xAA with other bytes from the SRAM, and the commit happens in the first cycle after the read.
- Write 0x11223344 to 0x40, then reads of 0x40, 0x44 and 0x40 back-to-back. Required: the buffer stays valid for 3 cycles, both 0x40 reads return 0x11223344, and SRAM_WE=0xF on the first non-read cycle.
- Write, read, write to 0x80, 0x84 and 0x88. Required: the 0x80 buffer commits in the 0x88 address phase, and 0x88 commits directly in its data phase.
- Halfword write 0xBEEF to 0x2 with DATA_WIDTH=32. Required: SRAM_WE=0b1100 and SRAM_WDATA[31:16]=0xBEEF.

Source files
------------

// File: rtl/aha_ahb_sram_bridge.sv
// rtl/aha_ahb_sram_bridge.sv - AHB-Lite slave to single-port byte-strobed SRAM bridge
// Zero-wait-state reads and writes via a one-entry write buffer with read-after-write byte merge.
module aha_ahb_sram_bridge #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              CLK,
    input  logic                              RESETn,
    input  logic                              HSEL,
    input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0] HADDR,
    input  logic [1:0]                        HTRANS,
    input  logic                              HWRITE,
    input  logic [2:0]                        HSIZE,
    input  logic [DATA_WIDTH-1:0]             HWDATA,
    input  logic                              HREADY,
    output logic                              HREADYOUT,
    output logic                              HRESP,
    output logic [DATA_WIDTH-1:0]             HRDATA,
    output logic                              SRAM_CS,
    output logic [DATA_WIDTH/8-1:0]           SRAM_WE,
    output logic [ADDR_WIDTH-1:0]             SRAM_ADDR,
    output logic [DATA_WIDTH-1:0]             SRAM_WDATA,
    input  logic [DATA_WIDTH-1:0]             SRAM_RDATA
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);

    logic                  trans;
    logic                  rap;
    logic                  wap;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic [NB-1:0]         hmask;
    logic [NB-1:0]         merge_next;

    logic                  wr_pend;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NB-1:0]         wr_mask;
    logic                  buf_valid;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [NB-1:0]         buf_mask;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [NB-1:0]         merge_mask;

    logic                  unused_ok;

    assign unused_ok  = HTRANS[0];
    assign trans      = HSEL & HREADY & HTRANS[1];
    assign rap        = trans & ~HWRITE;
    assign wap        = trans & HWRITE;
    assign haddr_word = HADDR[ADDR_WIDTH+OB-1:OB];
    assign HREADYOUT  = 1'b1;
    assign HRESP      = 1'b0;

    // Lane i belongs to the access when it shares the same size-aligned group as the address.
    always_comb begin
        hmask = '0;
        for (int i = 0; i < NB; i++) begin
            if (int'(HSIZE) >= OB)
                hmask[i] = 1'b1;
            else if ((i >> HSIZE) == (int'(HADDR[OB-1:0]) >> HSIZE))
                hmask[i] = 1'b1;
        end
    end

    always_comb begin
        merge_next = '0;
        if (buf_valid && buf_addr == haddr_word)
            merge_next = merge_next | buf_mask;
        if (wr_pend && wr_addr == haddr_word)
            merge_next = merge_next | wr_mask;
    end

    // Port priority: read address phase, then buffered write, then direct data-phase write.
    always_comb begin
        SRAM_CS    = 1'b0;
        SRAM_WE    = '0;
        SRAM_ADDR  = haddr_word;
        SRAM_WDATA = buf_data;
        if (RESETn) begin
            if (rap) begin
                SRAM_CS = 1'b1;
            end else if (buf_valid) begin
                SRAM_CS    = 1'b1;
                SRAM_WE    = buf_mask;
                SRAM_ADDR  = buf_addr;
                SRAM_WDATA = buf_data;
            end else if (wr_pend) begin
                SRAM_CS    = 1'b1;
                SRAM_WE    = wr_mask;
                SRAM_ADDR  = wr_addr;
                SRAM_WDATA = HWDATA;
            end
        end
    end

    always_comb begin
        HRDATA = SRAM_RDATA;
        for (int i = 0; i < NB; i++) begin
            if (merge_mask[i])
                HRDATA[8*i +: 8] = buf_data[8*i +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_pend    <= 1'b0;
            wr_addr    <= '0;
            wr_mask    <= '0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_mask   <= '0;
            buf_data   <= '0;
            merge_mask <= '0;
        end else begin
            wr_pend <= wap;
            if (wap) begin
                wr_addr <= haddr_word;
                wr_mask <= hmask;
            end
            // A data phase colliding with a read is parked; the buffer also serves as merge source.
            if (wr_pend && rap) begin
                buf_valid <= 1'b1;
                buf_addr  <= wr_addr;
                buf_mask  <= wr_mask;
                buf_data  <= HWDATA;
            end else if (buf_valid && !rap) begin
                buf_valid <= 1'b0;
            end
            merge_mask <= rap ? merge_next : '0;
        end
    end

endmodule
